// File: rtl/vga_timing_if.sv
// Pixel-timing bundle between vga_timing and the draw stages.
// The timing generator drives the counters and strobes; the consumer supplies the count enable.
`timescale 1ns/1ps
interface vga_timing_if;
  logic        en;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        frame_start;
  logic [15:0] frame_cnt;

  modport master (
    input  en,
    output hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );

  modport slave (
    output en,
    input  hcount, vcount, hsync, vsync, hblnk, vblnk, frame_start, frame_cnt
  );
endinterface

// File: rtl/vga_timing.sv
// Free-running SVGA timing generator: registered pixel/line counters with aligned strobes.
// Define VGA_TIMING_FRAME_CNT_EN to build the 16-bit completed-frame counter.
`timescale 1ns/1ps
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic          pclk,
  input  logic          rst,
  vga_timing_if.master  bus
);

  localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SON_C  = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SOFF_C = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] H_TOT_C  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SON_C  = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SOFF_C = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] V_TOT_C  = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q, frame_start_d;

  // Next counter position and strobes decoded from it, so registered strobes match registered counts.
  always_comb begin
    hcount_d = hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hcount_q >= (H_TOT_C - 11'd1)) begin
      hcount_d = 11'd0;
      if (vcount_q >= (V_TOT_C - 11'd1)) begin
        vcount_d = 11'd0;
      end else begin
        vcount_d = vcount_q + 11'd1;
      end
    end else if (vcount_q >= V_TOT_C) begin
      vcount_d = 11'd0;
    end else begin
      vcount_d = vcount_q;
    end
    hblnk_d       = (hcount_d >= H_ACT_C);
    hsync_d       = (hcount_d >= H_SON_C) && (hcount_d < H_SOFF_C);
    vblnk_d       = (vcount_d >= V_ACT_C);
    vsync_d       = (vcount_d >= V_SON_C) && (vcount_d < V_SOFF_C);
    frame_start_d = (hcount_d == 11'd0) && (vcount_d == 11'd0);
  end

  // Timing state; a low enable freezes everything, including a pending frame_start pulse.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      hcount_q      <= 11'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (bus.en) begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Completed frames advance on the same edge that raises frame_start.
  always_comb begin
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Frame counter register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
    end else if (bus.en) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.frame_cnt = frame_cnt_q;
`else
  assign bus.frame_cnt = 16'd0;
`endif

  assign bus.hcount      = hcount_q;
  assign bus.vcount      = vcount_q;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.hblnk       = hblnk_q;
  assign bus.vblnk       = vblnk_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: doc/vga_timing.md
# vga_timing

Free-running 800×600 @ 60 Hz SVGA timing generator clocked by the 40 MHz pixel clock; first stage of the vga_example pixel pipeline. Produces registered horizontal/vertical pixel counters plus sync and blanking strobes, consumed by the background/rectangle draw stages. The downstream frame capture in simulation relies on its 1056×628 total frame. All outputs are mutually aligned; downstream stages delay them together.

## Interface
Parameters:
- `H_ACTIVE`, 800, visible pixels per line
- `H_FP`, 40, horizontal front porch
- `H_SYNC`, 128, hsync width
- `H_BP`, 88, horizontal back porch (total 1056)
- `V_ACTIVE`, 600, visible lines
- `V_FP`, 1, vertical front porch
- `V_SYNC`, 4, vsync width
- `V_BP`, 23, vertical back porch (total 628)

Ports:
- `pclk`  in  1  pixel clock, 40 MHz, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  count enable; low freezes all state
- `hcount`  out  11  pixel index in line, 0..1055
- `vcount`  out  11  line index in frame, 0..627
- `hsync`  out  1  horizontal sync, active-high
- `vsync`  out  1  vertical sync, active-high
- `hblnk`  out  1  horizontal blanking
- `vblnk`  out  1  vertical blanking
- `frame_start`  out  1  one-cycle pulse at (0,0)
- `frame_cnt`  out  16  completed-frame count (see Configuration)

## Operation
- H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise; widths 11 bits, no overflow for defaults.
- On `en`=1 each edge: hcount increments; at H_TOT-1 wraps to 0 and vcount increments; at (H_TOT-1, V_TOT-1) both wrap to 0.
- `en`=0: every output register holds, including `frame_start` (held pulse stays asserted until `en` returns high and one edge passes).
- Strobes are decoded from the next counter value and registered, so each strobe describes the hcount/vcount present in the same cycle:
  - hblnk = hcount ≥ H_ACTIVE
  - hsync = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (840..967)
  - vblnk = vcount ≥ V_ACTIVE
  - vsync = V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (601..604), whole lines, asserted from hcount 0
  - frame_start = (hcount==0 && vcount==0) reached by counting, not by reset
- Reset (asynchronous, any time including mid-frame): hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0, frame_cnt=0. Timing restarts at (0,0) with no partial-frame recovery.
- Any counter value ≥ total (unreachable; guard only) wraps to 0 on the next enabled edge.

## Timing
- Zero-latency alignment: all outputs change together on the same `pclk` edge; no combinational output paths.
- First enabled edge after reset deassertion: hcount=1, vcount=0.
- Line period 1056 enabled cycles; frame 663 168 cycles = 16.579 ms at 40 MHz.
- hsync rises at edge producing hcount=840, falls at hcount=968.
- vsync rises with (hcount=0, vcount=601), falls with (0,605); vsync-low to vsync-low interval = 1 frame.
- frame_start high exactly one enabled cycle per frame, coincident with (0,0); not asserted after reset until first wrap.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined: 16-bit frame_cnt increments on each wrap to (0,0) (same edge as frame_start), wraps 65535→0, reset to 0.
- Undefined: counter logic absent, `frame_cnt` tied to 16'd0; all other behaviour identical.

## Test plan
- Reset low 800 ns, release, en=1 -> hcount=1 on first edge; hsync low and hblnk low through hcount=799; hblnk=1 at 800.
- Run one line -> hsync high for exactly 128 cycles starting at hcount=840; hcount 1055→0 with vcount 0→1.
- Run two frames -> vsync high for 4×1056 = 4224 cycles starting (0,601); negedge-to-negedge vsync spacing 663 168 cycles; frame_start pulses once per frame at (0,0).
- en=0 for 50 cycles at hcount=500, vcount=10 -> all outputs frozen; resume -> hcount=501 on next edge.
- Assert rst at (700,300) mid-frame -> all outputs zero immediately (before next edge); restart from (0,0).
- With VGA_TIMING_FRAME_CNT_EN: after 3 full frames frame_cnt=3; without macro frame_cnt=0 throughout.
